square_step: RTL and testbench

Sequential 32-bit squarer for the root-function datapath: the inverse of the bisection square-root unit. It holds a current operand, which is loaded directly or stepped up and down with NEXT/PREVIOUS. Every operand change triggers a shift-add computation of operand², reported with a BUSY/DONE handshake. It produces the reference squares that sqrt results are checked against and lets the front panel step through perfect squares.

---
 rtl/square_step.sv | 103 ++++++++++
 tb/tb_square_step.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/square_step.sv
// square_step: sequential 32-bit squarer. It holds an operand that can be loaded
// or stepped up or down. Every accepted command recomputes operand^2 by shift-add.
// BUSY is high during the computation, and DONE pulses for one cycle when SQ
// becomes valid.
// Optional build macro: SQUARE_STEP_EARLY_EXIT_EN. When it is defined, the
// computation stops once the remaining multiplier bits are all zero.
module square_step (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic        NEXT,
    input  logic        PREVIOUS,
    input  logic [31:0] N,
    output logic [31:0] VALUE,
    output logic [63:0] SQ,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]  state;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;

    logic        cmd;
    logic [31:0] new_value;
    logic [63:0] acc_sum;
    logic [31:0] mplier_shift;
    logic        calc_last;

    // Command decode, and one shift-add step of the multiplier.
    always_comb begin
        cmd          = LOAD | NEXT | PREVIOUS;
        new_value    = VALUE;
        if (NEXT && PREVIOUS) begin
            new_value = N;
        end else if (LOAD) begin
            new_value = N;
        end else if (NEXT) begin
            new_value = VALUE + 32'd1;
        end else if (PREVIOUS) begin
            new_value = VALUE - 32'd1;
        end
        acc_sum      = mplier[0] ? (acc + mcand) : acc;
        mplier_shift = mplier >> 1;
`ifdef SQUARE_STEP_EARLY_EXIT_EN
        calc_last    = (cnt == 5'd31) || (mplier_shift == 32'd0);
`else
        calc_last    = (cnt == 5'd31);
`endif
    end

    // Sequencer state, operand and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            VALUE  <= 32'd0;
            SQ     <= 64'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (cmd) begin
                        VALUE  <= new_value;
                        acc    <= 64'd0;
                        mcand  <= {32'b0, new_value};
                        mplier <= new_value;
                        cnt    <= 5'd0;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shift;
                    cnt    <= cnt + 5'd1;
                    if (calc_last) begin
                        SQ    <= acc_sum;
                        state <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode directly from the state.
    always_comb begin
        BUSY = (state == CALC);
        DONE = (state == FIN);
    end

endmodule

// File: tb/tb_square_step.sv
// Testbench for square_step. It uses a table of directed commands, each issued
// in FIN straight after the previous result, and then hand-written sequences
// for the ignored-while-busy, mid-calculation reset and reset-with-command cases.
module tb_square_step;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        LOAD;
    logic        NEXT;
    logic        PREVIOUS;
    logic [31:0] N;
    logic [31:0] VALUE;
    logic [63:0] SQ;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;
    logic [63:0] last_sq;

    square_step dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .LOAD     (LOAD),
        .NEXT     (NEXT),
        .PREVIOUS (PREVIOUS),
        .N        (N),
        .VALUE    (VALUE),
        .SQ       (SQ),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        l;
        logic        nx;
        logic        pv;
        logic [31:0] n;
        logic [31:0] ev;
        logic [63:0] esq;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected number of CALC edges for a given operand.
    function automatic int exp_lat(input logic [31:0] v);
`ifdef SQUARE_STEP_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 32; i++) if (v[i]) l = i + 1;
        return l;
`else
        return 32;
`endif
    endfunction

    // Waits for DONE after E0, counting edges. Returns with the clock at the FIN negedge.
    task automatic wait_done(input string name, output int edges, output logic seen);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (DONE) seen = 1'b1;
            else if (edges == 1) chk({name, "_sq_hold"}, SQ, last_sq);
        end
        chk({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    endtask

    // Issues one command at the current negedge and checks the whole transaction.
    task automatic run_cmd(input string name, input logic l, input logic nx, input logic pv,
                           input logic [31:0] n, input logic [31:0] ev, input logic [63:0] esq);
        int   edges;
        logic seen;
        LOAD = l; NEXT = nx; PREVIOUS = pv; N = n;
        @(posedge CLK);
        #1;
        LOAD = 1'b0; NEXT = 1'b0; PREVIOUS = 1'b0;
        @(negedge CLK);
        chk({name, "_value_e0"}, {32'd0, VALUE}, {32'd0, ev});
        chk({name, "_busy_e0"}, {63'd0, BUSY}, 64'd1);
        wait_done(name, edges, seen);
        chk({name, "_latency"}, 64'(edges), 64'(exp_lat(ev)));
        chk({name, "_sq"}, SQ, esq);
        chk({name, "_busy_fin"}, {63'd0, BUSY}, 64'd0);
        last_sq = esq;
    endtask

    initial begin
        int   edges;
        logic seen;
        int   dones;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd3,          32'd3,          64'd9};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd0,          32'd0,          64'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'd0,          32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd10,         32'd10,         64'd100};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'd7,          32'd7,          64'd49};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd7,          32'd7,          64'd49};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h80000000,   32'h80000000,   64'h4000000000000000};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'd0,          32'h7FFFFFFF,   64'h3FFFFFFF00000001};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'd5,          32'd5,          64'd25};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'd0,          32'd0,          64'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'd0,          32'd1,          64'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'd20,         32'd20,         64'd400};

        RESET = 1'b1; LOAD = 1'b0; NEXT = 1'b0; PREVIOUS = 1'b0; N = 32'd0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_value", {32'd0, VALUE}, 64'd0);
        chk("rst_sq", SQ, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        last_sq = 64'd0;

        for (int i = 0; i < 13; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].l, vecs[i].nx, vecs[i].pv,
                    vecs[i].n, vecs[i].ev, vecs[i].esq);
        end

        // NEXT pulsed while BUSY is dropped and not queued.
        LOAD = 1'b1; N = 32'd7;
        @(posedge CLK);
        #1 LOAD = 1'b0;
        @(negedge CLK);
        NEXT = 1'b1;
        @(posedge CLK);
        #1 NEXT = 1'b0;
        @(negedge CLK);
        chk("busy_next_value", {32'd0, VALUE}, 64'd7);
        edges = 0; seen = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (DONE) seen = 1'b1;
        end
        chk("busy_next_done", {63'd0, seen}, 64'd1);
        chk("busy_next_sq", SQ, 64'd49);
        repeat (3) @(negedge CLK);
        chk("busy_next_not_queued_busy", {63'd0, BUSY}, 64'd0);
        chk("busy_next_not_queued_value", {32'd0, VALUE}, 64'd7);

        // RESET on CALC edge 10 discards the pending result.
        LOAD = 1'b1; N = 32'd1000;
        @(posedge CLK);
        #1 LOAD = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        chk("midrst_busy_before", {63'd0, BUSY}, 64'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("midrst_value", {32'd0, VALUE}, 64'd0);
        chk("midrst_sq", SQ, 64'd0);
        chk("midrst_busy", {63'd0, BUSY}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);

        // A command coincident with RESET is dropped.
        RESET = 1'b1; LOAD = 1'b1; N = 32'd55;
        @(posedge CLK);
        #1 RESET = 1'b0; LOAD = 1'b0;
        @(negedge CLK);
        chk("rstcmd_value", {32'd0, VALUE}, 64'd0);
        chk("rstcmd_busy", {63'd0, BUSY}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
